// File: rtl/pool2x2_stream.sv
// Streaming 2x2/stride-2 max/average pooling for one channel of a raster-order feature map.
// A pair register merges horizontal neighbours; a half-row line buffer merges vertical pairs.
module pool2x2_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pool_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              frame_done
);

   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);
   localparam int HALF = IMG_W / 2;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [DATA_W-1:0] pair_q;
   logic              mode_q;
   logic              last_q;

   logic signed [DATA_W:0] line_buf [HALF];

   logic                     in_xfer, out_xfer;
   logic                     first_px, mode_eff;
   logic                     col_last, row_last, col_odd, row_odd;
   logic                     win_done;
   logic [BW-1:0]            buf_idx;
   logic signed [DATA_W:0]   pix_s, pair_s, pair_p, buf_v;
   logic signed [DATA_W+1:0] win_sum;
   logic [DATA_W-1:0]        win_val;

   // Valid/ready: a beat moves on a rising edge where valid && ready; the producer holds
   // valid and data steady until that edge, and ready may depend combinationally on out_ready.
   assign in_ready = !out_valid || out_ready;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   assign first_px = (col == '0) && (row == '0);
   // The first pixel of a frame uses the live pool_mode, not the previous frame's latch.
   assign mode_eff = first_px ? pool_mode : mode_q;
   assign col_last = (col == CW'(IMG_W - 1));
   assign row_last = (row == RW'(IMG_H - 1));
   assign col_odd  = col[0];
   assign row_odd  = row[0];
   assign win_done = in_xfer && col_odd && row_odd;
   assign buf_idx  = BW'(col >> 1);

   assign pix_s  = {in_data[DATA_W-1], in_data};
   assign pair_s = {pair_q[DATA_W-1], pair_q};
   assign pair_p = mode_eff ? (pair_s + pix_s) : ((pair_s > pix_s) ? pair_s : pix_s);
   assign buf_v  = line_buf[buf_idx];

   // Two extra bits over a pixel hold the sum of four pixels; floor division is >>> 2.
   assign win_sum = {buf_v[DATA_W], buf_v} + {pair_p[DATA_W], pair_p};
   assign win_val = mode_eff ? DATA_W'(win_sum >>> 2)
                             : DATA_W'((buf_v > pair_p) ? buf_v : pair_p);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         pair_q     <= '0;
         mode_q     <= 1'b0;
         last_q     <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_xfer && last_q;
         if (in_xfer) begin
            if (first_px) mode_q <= pool_mode;
            if (!col_odd) pair_q <= in_data;
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (win_done) begin
            out_valid <= 1'b1;
            out_data  <= win_val;
            last_q    <= row_last && col_last;
         end else if (out_xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Buffer contents need no reset: each entry is written on an even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (in_xfer && col_odd && !row_odd) line_buf[buf_idx] <= pair_p;
   end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Randomised bench for pool2x2_stream: frames are pooled by a plain-arithmetic window model
// whose results are queued and checked by an independent output monitor.
module tb_pool2x2_stream;

   localparam int DATA_W = 8;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;

   logic              clk_tb;
   logic              rst;
   logic              pool_mode;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              frame_done;

   logic [DATA_W:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int bp_mode  = 2;

   pool2x2_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk(clk_tb), .rst(rst), .pool_mode(pool_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .frame_done(frame_done)
   );

   // clock / reset
   initial clk_tb = 1'b0;
   always #5 clk_tb = ~clk_tb;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // downstream backpressure: 0 random, 1 always stalled, 2 always ready
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk_tb);
         #1;
         case (bp_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // driver tasks
   task automatic drive_px(input int d, input logic m);
      bit acc;
      int n;
      pool_mode = m;
      in_data   = DATA_W'(d);
      in_valid  = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         @(negedge clk_tb);
         acc = in_ready;
         @(posedge clk_tb);
         #1;
         n++;
      end
      if (!acc) check(1'b0, "input_accept_timeout", n, 0);
      in_valid  = 1'b0;
      pool_mode = logic'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk_tb);
      #1;
   endtask

   function automatic int floor_div4(input int s);
      return (s >= 0) ? s / 4 : -((-s + 3) / 4);
   endfunction

   // kind: 0 random, 1 all minimum, 2 all maximum, 3 fixed pattern
   task automatic send_frame(input logic mode, input int kind);
      int pix[IMG_H][IMG_W];
      int pat[4][4] = '{'{10, 20, -5, -7}, '{30, 40, -6, -8},
                        '{-128, 127, 0, -1}, '{127, -128, 1, 0}};
      int a, b, c, d, e;
      bit last;
      for (int r = 0; r < IMG_H; r++)
         for (int k = 0; k < IMG_W; k++)
            case (kind)
               1:       pix[r][k] = -128;
               2:       pix[r][k] = 127;
               3:       pix[r][k] = pat[r % 4][k % 4];
               default: pix[r][k] = int'($urandom_range(0, 255)) - 128;
            endcase
      for (int wr = 0; wr < IMG_H / 2; wr++)
         for (int wc = 0; wc < IMG_W / 2; wc++) begin
            a = pix[2*wr][2*wc];   b = pix[2*wr][2*wc+1];
            c = pix[2*wr+1][2*wc]; d = pix[2*wr+1][2*wc+1];
            if (mode) e = floor_div4(a + b + c + d);
            else begin
               e = a;
               if (b > e) e = b;
               if (c > e) e = c;
               if (d > e) e = d;
            end
            last = (wr == IMG_H / 2 - 1) && (wc == IMG_W / 2 - 1);
            exp_q.push_back({last, DATA_W'(e)});
         end
      for (int r = 0; r < IMG_H; r++)
         for (int k = 0; k < IMG_W; k++)
            // only the first pixel carries the frame mode; later pixels toggle it randomly
            drive_px(pix[r][k], (r == 0 && k == 0) ? mode : logic'($urandom_range(0, 1)));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk_tb);
         n++;
      end
      if (exp_q.size() != 0) check(1'b0, "drain_timeout", exp_q.size(), 0);
      repeat (3) @(posedge clk_tb);
      #1;
   endtask

   // scoreboard monitor
   initial begin
      logic [DATA_W:0] e;
      bit fd_next;
      fd_next = 1'b0;
      forever begin
         @(negedge clk_tb);
         if (rst) begin
            fd_next = 1'b0;
         end else begin
            check(frame_done == fd_next, "frame_done", int'(frame_done), int'(fd_next));
            check(in_ready == (!out_valid || out_ready), "in_ready", int'(in_ready),
                  int'(!out_valid || out_ready));
            fd_next = 1'b0;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_output", int'($signed(out_data)), 0);
               end else begin
                  e = exp_q.pop_front();
                  check(out_data == e[DATA_W-1:0], "out_data", int'($signed(out_data)),
                        int'($signed(e[DATA_W-1:0])));
                  fd_next = e[DATA_W];
               end
            end
         end
      end
   end

   // main sequence
   initial begin
      rst = 1'b1;
      pool_mode = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      #3;
      check(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
      check(out_data == '0, "reset_out_data", int'(out_data), 0);
      check(frame_done == 1'b0, "reset_frame_done", int'(frame_done), 0);
      repeat (2) @(negedge clk_tb);
      rst = 1'b0;
      @(posedge clk_tb);
      #1;

      bp_mode = 2;
      send_frame(1'b1, 3);
      send_frame(1'b0, 3);
      send_frame(1'b0, 1);
      send_frame(1'b1, 2);
      send_frame(1'b1, 1);
      drain();

      // long downstream stall in the middle of a frame
      bp_mode = 1;
      fork
         send_frame(1'b0, 3);
         begin
            repeat (25) @(posedge clk_tb);
            #1;
            bp_mode = 2;
         end
      join
      drain();

      // reset while a result is pending, then a fresh frame
      bp_mode = 1;
      repeat (1) @(posedge clk_tb);
      #1;
      for (int i = 0; i < IMG_W + 2; i++) drive_px(int'($urandom_range(0, 255)) - 128, 1'b1);
      check(out_valid == 1'b1, "pending_before_reset", int'(out_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check(out_valid == 1'b0, "async_reset_out_valid", int'(out_valid), 0);
      check(out_data == '0, "async_reset_out_data", int'(out_data), 0);
      @(negedge clk_tb);
      rst = 1'b0;
      @(posedge clk_tb);
      #1;
      bp_mode = 0;
      send_frame(1'b0, 3);
      drain();

      for (int f = 0; f < 8; f++) send_frame(logic'($urandom_range(0, 1)), 0);
      drain();
      bp_mode = 2;
      for (int f = 0; f < 4; f++) send_frame(logic'($urandom_range(0, 1)), 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
